// File: rtl/q2_memio.sv
// q2_memio: CPU memory-mapped RAM, output-port FIFO at all-ones, input port at all-ones minus 1,
// plus a saturating run-cycle counter and a halt pulse.
module q2_memio #(
    parameter int WIDTH     = 12,
    parameter int AWIDTH    = 12,
    parameter int OUT_DEPTH = 4,
    parameter int CWIDTH    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] abus,
    inout  wire  [WIDTH-1:0]  dbus,
    input  logic              wrm,
    input  logic              rdm,
    input  logic              run,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ack,
    output logic              overflow,
    output logic [CWIDTH-1:0] cycles,
    output logic              halted
);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int NW = $clog2(OUT_DEPTH + 1);
    localparam logic [AWIDTH-1:0] OUT_ADDR = '1;
    localparam logic [AWIDTH-1:0] IN_ADDR  = {{(AWIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0]  r_mem [2**AWIDTH];
    logic [WIDTH-1:0]  r_fifo [OUT_DEPTH];
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [NW-1:0]     r_count;
    logic              r_overflow;
    logic              r_in_ack;
    logic              r_halted;
    logic              r_run_prev;
    logic [CWIDTH-1:0] r_cycles;

    logic             w_is_out;
    logic             w_is_in;
    logic             w_is_ram;
    logic             w_rd;
    logic             w_full;
    logic             w_pop;
    logic             w_push_req;
    logic             w_push;
    logic [WIDTH-1:0] w_status;
    logic [WIDTH-1:0] w_rdata;

    assign w_is_out   = abus == OUT_ADDR;
    assign w_is_in    = abus == IN_ADDR;
    assign w_is_ram   = !w_is_out && !w_is_in;
    assign w_rd       = rdm && !wrm;
    assign w_full     = r_count == NW'(OUT_DEPTH);
    assign w_pop      = out_valid && out_ready;
    assign w_push_req = wrm && w_is_out;
    // a full FIFO still accepts a push when the head leaves on the same edge
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_comb begin
        w_status            = '0;
        w_status[WIDTH-1]   = r_overflow;
        w_status[NW-1:0]    = r_count;
    end

    assign w_rdata = w_is_out ? w_status : w_is_in ? in_data : r_mem[abus];
    assign dbus    = w_rd ? w_rdata : 'z;

    always_ff @(posedge clk) begin
        if (wrm && w_is_ram) r_mem[abus] <= dbus;
        if (w_push) r_fifo[r_wr_ptr] <= dbus;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_in_ack   <= 1'b0;
            r_halted   <= 1'b0;
            r_run_prev <= 1'b0;
            r_cycles   <= '0;
        end else begin
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            r_count <= r_count + NW'(w_push) - NW'(w_pop);
            if (w_push_req && !w_push) r_overflow <= 1'b1;
            r_in_ack   <= w_rd && w_is_in;
            r_run_prev <= run;
            r_halted   <= r_run_prev && !run;
            if (run && r_cycles != '1) r_cycles <= r_cycles + CWIDTH'(1);
        end
    end

    assign out_valid = r_count != '0;
    assign out_data  = r_fifo[r_rd_ptr];
    assign in_ack    = r_in_ack;
    assign overflow  = r_overflow;
    assign cycles    = r_cycles;
    assign halted    = r_halted;
endmodule

// File: tb/tb_q2_memio.sv
// tb_q2_memio: vector table, directed corner sequences and a randomized run
// checked against a queue/associative-array model of the memory-mapped I/O.
module tb_q2_memio;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] abus, in_data, out_data, tb_d;
    logic        wrm, rdm, run, out_ready, out_valid, in_ack, overflow, halted, tb_en;
    logic [31:0] cycles;
    wire  [11:0] dbus;
    assign dbus = tb_en ? tb_d : 'z;

    logic        run2, ov2, hl2, ia2, ov_valid2;
    logic [11:0] od2;
    logic [3:0]  cyc2;
    wire  [11:0] dbus2;
    assign dbus2 = 12'h000;

    always #5 clk = ~clk;

    q2_memio u_dut (
        .clk(clk), .rst(rst), .abus(abus), .dbus(dbus), .wrm(wrm), .rdm(rdm), .run(run),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_ack(in_ack), .overflow(overflow), .cycles(cycles), .halted(halted)
    );

    q2_memio #(.CWIDTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .abus(12'h000), .dbus(dbus2), .wrm(1'b0), .rdm(1'b0), .run(run2),
        .out_data(od2), .out_valid(ov_valid2), .out_ready(1'b0),
        .in_data(12'h000), .in_ack(ia2), .overflow(ov2), .cycles(cyc2), .halted(hl2)
    );

    int          q[$];
    logic [11:0] mem [int];
    bit          m_ovf, m_ack, m_halt, m_prev;
    logic [31:0] m_cyc;
    int          n_chk, n_fail;

    typedef struct {
        bit          w, r, rdy;
        logic [11:0] a, d, ind;
        int          kind;
        logic [15:0] exp;
        string       nm;
    } vec_t;

    function automatic vec_t v(bit w, bit r, logic [11:0] a, logic [11:0] d, bit rdy,
                               logic [11:0] ind, int kind, logic [15:0] exp, string nm);
        vec_t t;
        t.w = w; t.r = r; t.a = a; t.d = d; t.rdy = rdy; t.ind = ind;
        t.kind = kind; t.exp = exp; t.nm = nm;
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_ovf = 0; m_ack = 0; m_halt = 0; m_prev = 0; m_cyc = 0;
    endtask

    function automatic logic [11:0] m_read(logic [11:0] a);
        if (a == 12'hFFF) return (m_ovf ? 12'h800 : 12'h000) | 12'(q.size());
        if (a == 12'hFFE) return in_data;
        return mem[a];
    endfunction

    // called at posedge+1; returns at the next posedge+1
    task automatic cyc(bit w, bit r, logic [11:0] a, logic [11:0] d, bit rdy, bit rn,
                       logic [11:0] ind, int kind = 0, logic [15:0] exp = 0, string nm = "");
        bit popped;
        int sz;
        if (kind == 2) chk(nm, {out_valid, out_data}, exp[12:0]);
        if (kind == 3) chk(nm, out_valid, 0);
        if (kind == 4) chk(nm, in_ack, exp[0]);
        wrm = w; rdm = r; abus = a; tb_d = d; tb_en = w || !r;
        out_ready = rdy; run = rn; in_data = ind;
        #2;
        if (kind == 1) chk(nm, dbus, exp[11:0]);
        if (r && !w) begin
            if (a >= 12'hFFE || mem.exists(a)) chk("read_model", dbus, m_read(a));
        end else chk("bus_release", dbus, d);
        sz = q.size();
        popped = sz > 0 && rdy;
        if (popped) void'(q.pop_front());
        if (w && a == 12'hFFF) begin
            if (sz < 4 || popped) q.push_back(int'(d));
            else m_ovf = 1;
        end
        if (w && a < 12'hFFE) mem[a] = d;
        m_ack = r && !w && a == 12'hFFE;
        if (rn && m_cyc != 32'hFFFF_FFFF) m_cyc++;
        m_halt = m_prev && !rn;
        m_prev = rn;
        @(posedge clk); #1;
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) chk("out_data", out_data, q[0]);
        chk("overflow", overflow, m_ovf);
        chk("cycles", cycles, m_cyc);
        chk("halted", halted, m_halt);
        chk("in_ack", in_ack, m_ack);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        m_reset();
        rst = 1'b0;
    endtask

    initial begin
        vec_t        tv[$];
        int          k, hcnt;
        logic [11:0] ra;
        bit          rw, rr, rrun;
        rst = 1'b1; wrm = 0; rdm = 0; abus = 0; tb_d = 0; tb_en = 1; out_ready = 0;
        run = 0; run2 = 0; in_data = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_halted", halted, 0);
        chk("rst_in_ack", in_ack, 0);
        m_reset();
        rst = 1'b0;

        tv.push_back(v(1, 0, 12'h010, 12'h123, 0, 0, 0, 0, ""));
        tv.push_back(v(0, 1, 12'h010, 0, 0, 0, 1, 16'h0123, "ram_read"));
        for (int i = 1; i <= 5; i++) tv.push_back(v(1, 0, 12'hFFF, 12'(i), 0, 0, 0, 0, ""));
        tv.push_back(v(0, 1, 12'hFFF, 0, 0, 0, 1, 16'h0804, "status_full_ovf"));
        for (int i = 1; i <= 4; i++) tv.push_back(v(0, 0, 0, 0, 1, 0, 2, 16'h1000 + 16'(i), "drain"));
        tv.push_back(v(0, 0, 0, 0, 1, 0, 3, 0, "drained_empty"));
        tv.push_back(v(0, 1, 12'hFFE, 0, 0, 12'h5A5, 1, 16'h05A5, "in_read"));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 4, 16'h0001, "in_ack_high"));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 4, 16'h0000, "in_ack_low"));
        tv.push_back(v(1, 0, 12'hFFE, 12'h777, 0, 0, 0, 0, ""));
        tv.push_back(v(0, 1, 12'hFFF, 0, 0, 0, 1, 16'h0800, "status_after_in_write"));
        tv.push_back(v(1, 1, 12'h011, 12'h456, 0, 0, 0, 0, ""));
        tv.push_back(v(0, 1, 12'h011, 0, 0, 0, 1, 16'h0456, "wr_priority"));
        tv.push_back(v(0, 1, 12'h010, 0, 0, 0, 1, 16'h0123, "ram_keep"));
        foreach (tv[i])
            cyc(tv[i].w, tv[i].r, tv[i].a, tv[i].d, tv[i].rdy, 0, tv[i].ind, tv[i].kind, tv[i].exp, tv[i].nm);

        // three queued words, 50 run cycles, then asynchronous reset between edges
        cyc(1, 0, 12'hFFF, 12'h111, 0, 1, 0);
        cyc(1, 0, 12'hFFF, 12'h222, 0, 1, 0);
        cyc(1, 0, 12'hFFF, 12'h333, 0, 1, 0);
        repeat (47) cyc(0, 0, 0, 0, 0, 1, 0);
        chk("cycles_50", cycles, 50);
        rst = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_cycles", cycles, 0);
        chk("async_overflow", overflow, 0);
        run = 0;
        @(posedge clk); #1;
        m_reset();
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, 3, 0, "post_rst_empty");
        cyc(0, 1, 12'h010, 0, 0, 0, 0, 1, 16'h0123, "ram_survives_rst");

        // full FIFO with simultaneous push and pop
        for (int i = 1; i <= 4; i++) cyc(1, 0, 12'hFFF, 12'(i), 0, 0, 0);
        cyc(1, 0, 12'hFFF, 12'h0AA, 1, 0, 0);
        cyc(0, 1, 12'hFFF, 0, 0, 0, 0, 1, 16'h0004, "full_pushpop_status");
        cyc(0, 0, 0, 0, 1, 0, 0, 2, 16'h1002, "pp_drain2");
        cyc(0, 0, 0, 0, 1, 0, 0, 2, 16'h1003, "pp_drain3");
        cyc(0, 0, 0, 0, 1, 0, 0, 2, 16'h1004, "pp_drain4");
        cyc(0, 0, 0, 0, 1, 0, 0, 2, 16'h10AA, "pp_drain_aa");
        cyc(0, 0, 0, 0, 1, 0, 0, 3, 0, "pp_empty");

        // empty FIFO with push and ready together
        cyc(1, 0, 12'hFFF, 12'h321, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 2, 16'h1321, "empty_push_lands");
        cyc(0, 0, 0, 0, 1, 0, 0, 2, 16'h1321, "empty_push_pop");
        cyc(0, 0, 0, 0, 0, 0, 0, 3, 0, "empty_again");

        // 100 run cycles on the wide counter, 20 on the 4-bit one
        for (int i = 0; i < 100; i++) begin
            run2 = i < 20;
            cyc(0, 0, 0, 0, 0, 1, 0);
        end
        run2 = 0;
        chk("cycles_100", cycles, 100);
        chk("cycles_sat_4bit", cyc2, 4'hF);
        hcnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            hcnt += int'(halted);
        end
        chk("halted_once", hcnt, 1);
        chk("cycles_hold", cycles, 100);

        rrun = 0;
        for (int i = 0; i < 500; i++) begin
            k = $urandom_range(9);
            ra = k < 8 ? 12'h010 + 12'(k) : (k == 8 ? 12'hFFE : 12'hFFF);
            rw = $urandom_range(99) < 40;
            rr = $urandom_range(99) < 50;
            rrun = $urandom_range(9) < 8 ? rrun : !rrun;
            cyc(rw, rr, ra, 12'($urandom), 1'($urandom_range(1)), rrun, 12'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/q2_memio.md
Q2_MEMIO -- requirements
Module: q2_memio

Interface
REQ-001 SHALL have parameter WIDTH, default 12: data word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 12: address width in bits; RAM depth is 2**AWIDTH words.
REQ-003 SHALL have parameter OUT_DEPTH, default 4: output FIFO depth in words, a power of two, at least 2.
REQ-004 SHALL have parameter CWIDTH, default 32: run-cycle counter width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port abus, input, AWIDTH bits: CPU address bus.
REQ-008 SHALL have port dbus, inout, WIDTH bits: CPU data bus, driven by this block only during reads.
REQ-009 SHALL have ports wrm and rdm, input, 1 bit each: CPU write strobe and CPU read strobe.
REQ-010 SHALL have port run, input, 1 bit: CPU run indicator.
REQ-011 SHALL have ports out_data (output, WIDTH bits), out_valid (output, 1 bit) and out_ready (input, 1 bit): output-port stream.
REQ-012 SHALL have ports in_data (input, WIDTH bits) and in_ack (output, 1 bit): input-port sample and its read acknowledge.
REQ-013 SHALL have ports overflow (output, 1 bit), cycles (output, CWIDTH bits) and halted (output, 1 bit).

Function
REQ-014 SHALL decode three regions: OUT_ADDR = all ones, IN_ADDR = all ones minus 1, RAM = every other address.
REQ-015 SHALL write dbus into RAM[abus] on the rising clk edge when wrm=1 and abus is a RAM address.
REQ-016 SHALL drive dbus combinationally with RAM[abus] when rdm=1, wrm=0 and abus is a RAM address; read has zero-cycle latency.
REQ-017 SHALL drive dbus with in_data on a read of IN_ADDR, and SHALL pulse in_ack high for exactly the following cycle.
REQ-018 SHALL drive dbus with status on a read of OUT_ADDR: bit WIDTH-1 = overflow, low bits = FIFO occupancy (0..OUT_DEPTH), zeros elsewhere.
REQ-019 SHALL leave dbus at high impedance whenever rdm=0, or whenever rdm=1 and wrm=1 (write has priority).
REQ-020 SHALL push dbus into the output FIFO on a clk edge with wrm=1 and abus=OUT_ADDR when the FIFO is not full.
REQ-021 SHALL drop a write to OUT_ADDR made while the FIFO is full, and SHALL set overflow; overflow is sticky until reset.
REQ-022 SHALL present the FIFO head on out_data with out_valid=1 whenever occupancy > 0; data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 SHALL pop one word on each clk edge with out_valid=1 and out_ready=1.
REQ-024 SHALL accept a simultaneous push and pop when full (occupancy unchanged, no overflow).
REQ-025 SHALL NOT pop on a simultaneous push and pop when empty; the push lands and out_valid rises the next cycle.
REQ-026 SHALL wrap FIFO read and write pointers modulo OUT_DEPTH.
REQ-027 SHALL increment cycles on every clk edge with run=1, and SHALL saturate at all ones rather than wrap.
REQ-028 SHALL pulse halted high for one cycle on the clk edge after run is sampled going from 1 to 0.
REQ-029 SHALL ignore a write to IN_ADDR, with no state change.

Reset
REQ-030 SHALL, on rst asserted, immediately and asynchronously clear: FIFO pointers and occupancy, out_valid, overflow, in_ack, halted, cycles and the stored previous-run bit.
REQ-031 SHALL NOT clear RAM contents on reset; contents before first write are undefined (preload by simulation only).
REQ-032 SHALL, on rst asserted mid-transfer, discard all FIFO contents; out_valid SHALL be 0 in the first cycle after rst deasserts.

Verification
REQ-033 Scenario: write 12'h123 to addr 12'h010, then read addr 12'h010 -> dbus=12'h123 in the same cycle; dbus=Z when rdm=0.
REQ-034 Scenario: with out_ready=0, write 12'h001..12'h005 to 12'hFFF -> four words held, overflow=1, status read = 12'h804; then out_ready=1 -> 001,002,003,004 in order, then out_valid=0.
REQ-035 Scenario: FIFO full, same-cycle push of 12'h0AA and pop -> occupancy stays 4, overflow stays 0, 12'h0AA is delivered last.
REQ-036 Scenario: in_data=12'h5A5, read 12'hFFE -> dbus=12'h5A5 and in_ack=1 for exactly one cycle.
REQ-037 Scenario: run=1 for 100 cycles then 0 -> cycles=100, halted pulses once; with CWIDTH=4, 20 run cycles -> cycles=4'hF.
REQ-038 Scenario: assert rst with 3 words queued and cycles=50 -> out_valid=0, cycles=0, overflow=0 without a clk edge; RAM[12'h010] keeps 12'h123.
